// File: rtl/uart_bus_loader.sv
// uart_bus_loader
//   Host-driven bus initiator. Bytes from the UART rx FIFO form commands
//   (W addr data, R addr, H, G). The loader runs the matching single-word
//   transfers on the CPU memory bus and pushes reply bytes into the tx FIFO.
//   While cpu_hold is high the CPU sits in reset and the loader owns the bus.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   rx_data/rx_empty  head of rx FIFO / FIFO empty
//   rx_pop            consume head byte (one-cycle pulse)
//   tx_data/tx_push   reply byte / write it into tx FIFO (only when !tx_full)
//   tx_full           tx FIFO full
//   addr, wdata       bus word address (byte addr [31:2]) and write data
//   we, re            byte write enables (0000 or 1111) / read enable
//   rdata             read data, valid the cycle after an accepted read
//   mem_ready         responder accepts the request this cycle
//   cpu_hold          high: CPU held in reset, loader owns the bus
module uart_bus_loader #(
  parameter logic       HOLD_ON_RESET = 1'b1,
  parameter logic [7:0] ACK_BYTE      = 8'h4B,
  parameter logic [7:0] NAK_BYTE      = 8'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  output logic        tx_push,
  output logic [29:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  we,
  output logic        re,
  input  logic [31:0] rdata,
  input  logic        mem_ready,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    S_CMD    = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_BUS    = 3'd3,
    S_RDWAIT = 3'd4,
    S_REPLY  = 3'd5
  } state_t;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;

  state_t      state;
  logic [1:0]  cnt;        // operand / reply byte index
  logic        gap;        // previous cycle popped: rx head is settling
  logic        is_read;    // current command replies with 4 data bytes
  logic [23:2] addr_lo;    // address bytes 0..2 (byte-address bits [1:0] dropped)
  logic [29:0] word_addr;  // assembled word address, parked until S_BUS
  logic [23:0] data_lo;    // write data bytes 0..2
  logic [31:8] rbuf;       // read bytes 1..3; byte 0 goes straight to tx_data
  logic        rx_take;

  // Pop and push must react to rx_empty / tx_full in the same cycle to hit
  // one byte every two cycles and to never push into a full FIFO, so these
  // two strobes are decoded from registered state rather than registered.
  // gap resets high so the first cycle out of reset never pops.
  assign rx_take = reset && !gap && !rx_empty &&
                   (state == S_CMD || state == S_ADDR || state == S_DATA);
  assign rx_pop  = rx_take;
  assign tx_push = reset && (state == S_REPLY) && !tx_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_CMD;
      cnt       <= 2'd0;
      gap       <= 1'b1;
      is_read   <= 1'b0;
      addr_lo   <= '0;
      word_addr <= '0;
      data_lo   <= '0;
      rbuf      <= '0;
      addr      <= '0;
      wdata     <= '0;
      we        <= 4'h0;
      re        <= 1'b0;
      tx_data   <= 8'h00;
      cpu_hold  <= HOLD_ON_RESET;
    end else begin
      gap <= rx_take;
      case (state)
        S_CMD: begin
          if (rx_take) begin
            cnt <= 2'd0;
            case (rx_data)
              CMD_W: begin
                is_read <= 1'b0;
                state   <= S_ADDR;
              end
              CMD_R: begin
                is_read <= 1'b1;
                state   <= S_ADDR;
              end
              CMD_H: begin
                is_read  <= 1'b0;
                cpu_hold <= 1'b1;
                tx_data  <= ACK_BYTE;
                state    <= S_REPLY;
              end
              CMD_G: begin
                is_read  <= 1'b0;
                cpu_hold <= 1'b0;
                tx_data  <= ACK_BYTE;
                state    <= S_REPLY;
              end
              default: begin
                is_read <= 1'b0;
                tx_data <= NAK_BYTE;
                state   <= S_REPLY;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (rx_take) begin
            cnt <= cnt + 2'd1;
            case (cnt)
              2'd0: addr_lo[7:2]   <= rx_data[7:2];
              2'd1: addr_lo[15:8]  <= rx_data;
              2'd2: addr_lo[23:16] <= rx_data;
              default: begin
                // last address byte: the full word address is known now
                word_addr <= {rx_data, addr_lo};
                if (is_read) begin
                  addr  <= {rx_data, addr_lo};
                  re    <= 1'b1;
                  state <= S_BUS;
                end else begin
                  state <= S_DATA;
                end
              end
            endcase
          end
        end

        S_DATA: begin
          if (rx_take) begin
            cnt <= cnt + 2'd1;
            case (cnt)
              2'd0: data_lo[7:0]   <= rx_data;
              2'd1: data_lo[15:8]  <= rx_data;
              2'd2: data_lo[23:16] <= rx_data;
              default: begin
                addr  <= word_addr;
                wdata <= {rx_data, data_lo};
                we    <= 4'hF;
                state <= S_BUS;
              end
            endcase
          end
        end

        S_BUS: begin
          // request held stable until the responder accepts it
          if (mem_ready) begin
            we  <= 4'h0;
            re  <= 1'b0;
            cnt <= 2'd0;
            if (is_read) begin
              state <= S_RDWAIT;
            end else begin
              tx_data <= ACK_BYTE;
              state   <= S_REPLY;
            end
          end
        end

        S_RDWAIT: begin
          rbuf    <= rdata[31:8];
          tx_data <= rdata[7:0];
          cnt     <= 2'd0;
          state   <= S_REPLY;
        end

        S_REPLY: begin
          if (tx_push) begin
            if (!is_read || cnt == 2'd3) begin
              cnt   <= 2'd0;
              state <= S_CMD;
            end else begin
              cnt <= cnt + 2'd1;
              case (cnt)
                2'd0:    tx_data <= rbuf[15:8];
                2'd1:    tx_data <= rbuf[23:16];
                default: tx_data <= rbuf[31:24];
              endcase
            end
          end
        end

        default: state <= S_CMD;
      endcase
    end
  end

endmodule
